// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: the frame FSM state type and the
// oversampling constants used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

endpackage

// File: rtl/uart_fifo.sv
// Circular FIFO with registered full/empty flags and a first-word-fall-through
// read port. Used as the RX and TX buffers of uart_core.
module uart_fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_rd,
    input  logic         i_wr,
    input  logic [B-1:0] i_w_data,
    output logic         o_empty,
    output logic         o_full,
    output logic [B-1:0] o_r_data
);

    logic [B-1:0] mem [2**W];
    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_nx;
    logic [W-1:0] r_ptr_nx;
    logic         do_wr;
    logic         do_rd;

    // A write into a full FIFO is still accepted when a read frees the head slot.
    assign do_wr    = i_wr && (!o_full || i_rd);
    assign do_rd    = i_rd && !o_empty;
    assign w_ptr_nx = w_ptr + 1'b1;
    assign r_ptr_nx = r_ptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < 2**W; i++) begin
                mem[i[W-1:0]] <= '0;
            end
            w_ptr   <= '0;
            r_ptr   <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            if (do_wr) begin
                mem[w_ptr] <= i_w_data;
                w_ptr      <= w_ptr_nx;
            end
            if (do_rd) begin
                r_ptr <= r_ptr_nx;
            end
            if (do_wr && !do_rd) begin
                o_empty <= 1'b0;
                o_full  <= (w_ptr_nx == r_ptr);
            end else if (do_rd && !do_wr) begin
                o_full  <= 1'b0;
                o_empty <= (r_ptr_nx == w_ptr);
            end
        end
    end

    assign o_r_data = mem[r_ptr];

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: baud tick generator, 16x oversampling receiver and transmitter,
// each direction buffered by uart_fifo. Define UART_FRAME_ERR_EN to add o_frame_err.
module uart_core
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int FIFO_W  = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rd_uart,
    input  logic            i_wr_uart,
    input  logic            i_rx,
    input  logic [DBIT-1:0] i_w_data,
    output logic            o_tx_full,
    output logic            o_rx_empty,
    output logic            o_tx,
    output logic [DBIT-1:0] o_r_data
`ifdef UART_FRAME_ERR_EN
    ,
    output logic            o_frame_err
`endif
);

    localparam int BW = $clog2(DVSR + 1);
    localparam int SW = 6;
    localparam int NW = $clog2(DBIT + 1);

    logic [BW-1:0]   baud_cnt;
    logic            tick;

    logic [1:0]      rx_sync;
    logic            rx_in;
    uart_state_t     rx_state, rx_state_nx;
    logic [SW-1:0]   rx_s, rx_s_nx;
    logic [NW-1:0]   rx_n, rx_n_nx;
    logic [DBIT-1:0] rx_b, rx_b_nx;
    logic            rx_done;
    logic            rx_full_unused;

    uart_state_t     tx_state, tx_state_nx;
    logic [SW-1:0]   tx_s, tx_s_nx;
    logic [NW-1:0]   tx_n, tx_n_nx;
    logic [DBIT-1:0] tx_b, tx_b_nx;
    logic            tx_reg, tx_nx;
    logic            tx_done;
    logic            tx_empty;
    logic [DBIT-1:0] tx_head;

`ifdef UART_FRAME_ERR_EN
    logic            rx_ferr;
`endif

    // Baud tick: one-cycle pulse every DVSR clocks, free running.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            baud_cnt <= '0;
        end else if (baud_cnt == BW'(DVSR - 1)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign tick = (baud_cnt == BW'(DVSR - 1));

    // i_rx is asynchronous to i_clk; two flops before any decision is taken on it.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], i_rx};
        end
    end

    assign rx_in = rx_sync[1];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rx_state <= IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            tx_state <= IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_reg   <= 1'b1;
        end else begin
            rx_state <= rx_state_nx;
            rx_s     <= rx_s_nx;
            rx_n     <= rx_n_nx;
            tx_state <= tx_state_nx;
            tx_s     <= tx_s_nx;
            tx_n     <= tx_n_nx;
            tx_reg   <= tx_nx;
        end
    end

    always_ff @(posedge i_clk) begin
        rx_b <= rx_b_nx;
        tx_b <= tx_b_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_s_nx     = rx_s;
        rx_n_nx     = rx_n;
        rx_b_nx     = rx_b;
        rx_done     = 1'b0;
`ifdef UART_FRAME_ERR_EN
        rx_ferr     = 1'b0;
`endif
        case (rx_state)
            IDLE: begin
                if (!rx_in) begin
                    rx_state_nx = START;
                    rx_s_nx     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s == SW'(START_MID)) begin
                        // A start bit that is gone by mid-bit was a glitch.
                        rx_state_nx = rx_in ? IDLE : DATA;
                        rx_s_nx     = '0;
                        rx_n_nx     = '0;
                    end else begin
                        rx_s_nx = rx_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_s == SW'(OVERSAMPLE - 1)) begin
                        rx_s_nx = '0;
                        rx_b_nx = {rx_in, rx_b[DBIT-1:1]};
                        if (rx_n == NW'(DBIT - 1)) begin
                            rx_state_nx = STOP;
                        end else begin
                            rx_n_nx = rx_n + 1'b1;
                        end
                    end else begin
                        rx_s_nx = rx_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s == SW'(SB_TICK - 1)) begin
                        rx_state_nx = IDLE;
`ifdef UART_FRAME_ERR_EN
                        rx_done = rx_in;
                        rx_ferr = !rx_in;
`else
                        rx_done = 1'b1;
`endif
                    end else begin
                        rx_s_nx = rx_s + 1'b1;
                    end
                end
            end
            default: rx_state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_s_nx     = tx_s;
        tx_n_nx     = tx_n;
        tx_b_nx     = tx_b;
        tx_nx       = tx_reg;
        tx_done     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_nx = 1'b1;
                if (!tx_empty) begin
                    tx_state_nx = START;
                    tx_s_nx     = '0;
                    tx_b_nx     = tx_head;
                end
            end
            START: begin
                tx_nx = 1'b0;
                if (tick) begin
                    if (tx_s == SW'(OVERSAMPLE - 1)) begin
                        tx_state_nx = DATA;
                        tx_s_nx     = '0;
                        tx_n_nx     = '0;
                    end else begin
                        tx_s_nx = tx_s + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_nx = tx_b[0];
                if (tick) begin
                    if (tx_s == SW'(OVERSAMPLE - 1)) begin
                        tx_s_nx = '0;
                        tx_b_nx = tx_b >> 1;
                        if (tx_n == NW'(DBIT - 1)) begin
                            tx_state_nx = STOP;
                        end else begin
                            tx_n_nx = tx_n + 1'b1;
                        end
                    end else begin
                        tx_s_nx = tx_s + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_nx = 1'b1;
                if (tick) begin
                    if (tx_s == SW'(SB_TICK - 1)) begin
                        tx_state_nx = IDLE;
                        tx_done     = 1'b1;
                    end else begin
                        tx_s_nx = tx_s + 1'b1;
                    end
                end
            end
            default: tx_state_nx = IDLE;
        endcase
    end

    assign o_tx = tx_reg;

`ifdef UART_FRAME_ERR_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= rx_ferr;
        end
    end
`endif

    // The TX head is popped only when its frame has fully left the pin.
    uart_fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_rd     (tx_done),
        .i_wr     (i_wr_uart),
        .i_w_data (i_w_data),
        .o_empty  (tx_empty),
        .o_full   (o_tx_full),
        .o_r_data (tx_head)
    );

    uart_fifo #(.B(DBIT), .W(FIFO_W)) u_rx_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_rd     (i_rd_uart),
        .i_wr     (rx_done),
        .i_w_data (rx_b),
        .o_empty  (o_rx_empty),
        .o_full   (rx_full_unused),
        .o_r_data (o_r_data)
    );

endmodule

// File: tb/tb_uart_core.sv
// Directed/randomized bench for uart_core with a queue-based reference of the RX stream.
// Uses a short baud divisor so every frame-level scenario fits a small cycle budget.
module tb_uart_core;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int DVSR    = 5;
    localparam int FIFO_W  = 2;
    localparam int DEPTH   = 4;
    localparam int BITC    = 16 * DVSR;
    localparam int FRAME   = 10 * BITC;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rd;
    logic            wr;
    logic            rx_drv;
    logic            loop_en;
    logic [DBIT-1:0] wdata;
    logic            i_rx;
    logic            tx_full;
    logic            rx_empty;
    logic            tx;
    logic [DBIT-1:0] rdata;
`ifdef UART_FRAME_ERR_EN
    logic            frame_err;
    int              ferr_cnt = 0;
`endif

    int              tests  = 0;
    int              failed = 0;
    logic [7:0]      exp_q[$];

    assign i_rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .DVSR    (DVSR),
        .FIFO_W  (FIFO_W)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_rd_uart  (rd),
        .i_wr_uart  (wr),
        .i_rx       (i_rx),
        .i_w_data   (wdata),
        .o_tx_full  (tx_full),
        .o_rx_empty (rx_empty),
        .o_tx       (tx),
        .o_r_data   (rdata)
`ifdef UART_FRAME_ERR_EN
        ,
        .o_frame_err(frame_err)
`endif
    );

`ifdef UART_FRAME_ERR_EN
    always @(posedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    // Reference: the RX FIFO keeps at most DEPTH unread bytes, extras are lost.
    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] exp;
        exp = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h1ff;
        check(tag, {rx_empty, rdata}, exp);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic wait_rx(input int bound, input string tag);
        int k;
        k = 0;
        while (rx_empty && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, rx_empty, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_drv = 1'b0;
        tick_n(BITC);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick_n(BITC);
        end
        rx_drv = stop;
        tick_n(BITC);
        rx_drv = 1'b1;
        tick_n(BITC / 2);
    endtask

    initial begin
        int         lat;
        int         w;
        int         low_seen;
        logic [7:0] d;
        logic [7:0] pat [4];

        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; wdata = '0; rx_drv = 1'b1; loop_en = 1'b1;
        pat[0] = 8'h24; pat[1] = 8'h81; pat[2] = 8'h09; pat[3] = 8'h63;

        // Reset state
        tick_n(2);
        check("rst_tx", tx, 1'b1);
        check("rst_rx_empty", rx_empty, 1'b1);
        check("rst_tx_full", tx_full, 1'b0);
        check("rst_r_data", rdata, 8'h00);
        rst_n = 1'b1;
        tick_n(3);

        // TX bit timing of 0xA5 (looped back into RX as well)
        write_byte(8'hA5);
        model_push(8'hA5);
        lat = 1;
        while (tx && lat < 4 * DVSR) begin
            @(negedge clk);
            lat++;
        end
        check("tx_start_latency_le_tick", (lat <= DVSR), 1'b1);
        w = 0;
        while (!tx && w < 2 * BITC) begin
            @(negedge clk);
            w++;
        end
        check("tx_start_cell_len", (w >= 15 * DVSR && w <= 16 * DVSR + 1), 1'b1);
        w = 0;
        while (tx && w < 2 * BITC) begin
            @(negedge clk);
            w++;
        end
        check("tx_bit0_cell_len", w, BITC);
        tick_n(BITC / 2);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("tx_a5_cell%0d", k), tx, (k < 8) ? ((8'hA5 >> k) & 8'h01) : 8'h01);
            tick_n(BITC);
        end
        wait_rx(FRAME, "a5_rx_arrive");
        pop_check("a5_rx_data");
        check("a5_rx_empty_after", rx_empty, 1'b1);

        // Loopback of the fixed pattern, one frame at a time
        tick_n(BITC);
        for (int i = 0; i < 4; i++) begin
            write_byte(pat[i]);
            model_push(pat[i]);
            tick_n(FRAME + 50);
        end
        check("loop_rx_nonempty", rx_empty, 1'b0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("loop_rd%0d", i));
        check("loop_rx_empty_after", rx_empty, 1'b1);

        // TX FIFO full: five random bytes on consecutive clocks, fifth dropped
        for (int i = 0; i < 5; i++) begin
            d     = 8'($urandom);
            wdata = d;
            wr    = 1'b1;
            model_push(d);
            @(negedge clk);
            if (i >= 3) check($sformatf("tx_full_after_wr%0d", i + 1), tx_full, 1'b1);
        end
        wr = 1'b0;
        tick_n(4 * FRAME + 200);
        for (int i = 0; i < 4; i++) pop_check($sformatf("txfull_rd%0d", i));
        tick_n(FRAME + 100);
        check("txfull_no_fifth_frame", rx_empty, 1'b1);
        check("txfull_cleared", tx_full, 1'b0);

        // RX overflow from an external sender
        loop_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            model_push(d);
            send_frame(d, 1'b1);
        end
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_rd%0d", i));
        check("ovf_empty_after_4", rx_empty, 1'b1);

        // Start-bit glitch is rejected, a following good frame still lands
        rx_drv = 1'b0;
        tick_n(3 * DVSR);
        rx_drv = 1'b1;
        tick_n(FRAME);
        check("glitch_no_write", rx_empty, 1'b1);
        d = 8'($urandom);
        model_push(d);
        send_frame(d, 1'b1);
        pop_check("post_glitch_rd");

`ifdef UART_FRAME_ERR_EN
        // Bad stop bit: byte dropped, one error pulse
        send_frame(8'($urandom), 1'b0);
        tick_n(BITC);
        check("ferr_no_write", rx_empty, 1'b1);
        check("ferr_pulse_count", ferr_cnt, 1);
`endif

        // Reset in the middle of a TX frame
        write_byte(8'h3C);
        write_byte(8'hC3);
        tick_n(FRAME / 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx_high", tx, 1'b1);
        check("midrst_tx_full", tx_full, 1'b0);
        rst_n = 1'b1;
        low_seen = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (!tx) low_seen = 1;
        end
        check("midrst_tx_fifo_empty", low_seen, 0);
        check("midrst_rx_empty", rx_empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
